// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 key decoder: key ids, set-2 scan codes, FSM states
// and the scan-code to key-id lookup.
package ps2_key_decoder_pkg;

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_FIRE  = 3'd5;
  localparam logic [2:0] KEY_ENTER = 3'd6;
  localparam logic [2:0] KEY_ESC   = 3'd7;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_ESC     = 8'h76;
  localparam logic [7:0] SC_E_UP    = 8'h75;
  localparam logic [7:0] SC_E_DOWN  = 8'h72;
  localparam logic [7:0] SC_E_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       is_break;
    logic [2:0] key;
  } key_evt_t;

  // Extended and plain codes live in disjoint tables: E0 1D is not UP.
  function automatic logic [2:0] key_lookup(input logic [7:0] code, input logic ext);
    logic [2:0] id;
    id = KEY_NONE;
    if (ext) begin
      case (code)
        SC_E_UP:    id = KEY_UP;
        SC_E_DOWN:  id = KEY_DOWN;
        SC_E_LEFT:  id = KEY_LEFT;
        SC_E_RIGHT: id = KEY_RIGHT;
        default:    id = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_W:     id = KEY_UP;
        SC_S:     id = KEY_DOWN;
        SC_A:     id = KEY_LEFT;
        SC_D:     id = KEY_RIGHT;
        SC_SPACE: id = KEY_FIRE;
        SC_ENTER: id = KEY_ENTER;
        SC_ESC:   id = KEY_ESC;
        default:  id = KEY_NONE;
      endcase
    end
    return id;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the decoder's byte input, key-event handshake and status outputs.
interface ps2_key_decoder_if;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       evt_ready;
  logic       evt_valid;
  logic       evt_release;
  logic [2:0] evt_key;
  logic [7:0] held;
  logic [7:0] last_byte;
  logic       overflow;

  modport master (
    input  ps2_data, ps2_data_en, evt_ready,
    output evt_valid, evt_release, evt_key, held, last_byte, overflow
  );

  modport slave (
    output ps2_data, ps2_data_en, evt_ready,
    input  evt_valid, evt_release, evt_key, held, last_byte, overflow
  );
endinterface

// File: rtl/ps2_key_decoder_fifo.sv
// Show-ahead event FIFO; a push is accepted when full only if a pop frees a slot that cycle.
module ps2_key_decoder_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to game key events: E0/F0 prefix FSM with timeout,
// held-key bitmap, typematic repeat filter and a buffered event queue.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned FILTER_REPEAT  = 1
) (
  input  logic clock,
  input  logic resetn,
  ps2_key_decoder_if.master bus
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  dec_state_t    r_state;
  dec_state_t    w_state_next;
  logic [TW-1:0] r_timer;
  logic [7:1]    r_held;
  logic [7:0]    r_last_byte;
  logic          r_overflow;

  logic          w_timeout;
  logic          w_decode;
  logic          w_is_break;
  logic          w_ext;
  logic [2:0]    w_key;
  logic [7:0]    w_held_full;
  logic          w_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  key_evt_t      w_head;

  assign w_timeout = (r_state != ST_IDLE) && !bus.ps2_data_en
                     && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    w_decode     = 1'b0;
    w_is_break   = 1'b0;
    w_ext        = 1'b0;
    if (bus.ps2_data_en) begin
      w_state_next = ST_IDLE;
      case (r_state)
        ST_IDLE: begin
          if (bus.ps2_data == SC_EXT)      w_state_next = ST_EXT;
          else if (bus.ps2_data == SC_BRK) w_state_next = ST_BRK;
          else                             w_decode = 1'b1;
        end
        ST_EXT: begin
          w_ext = 1'b1;
          if (bus.ps2_data == SC_BRK)      w_state_next = ST_EXT_BRK;
          else if (bus.ps2_data == SC_EXT) w_state_next = ST_EXT;
          else                             w_decode = 1'b1;
        end
        ST_BRK: begin
          w_is_break = 1'b1;
          w_decode   = (bus.ps2_data != SC_EXT) && (bus.ps2_data != SC_BRK);
        end
        default: begin
          w_ext      = 1'b1;
          w_is_break = 1'b1;
          w_decode   = (bus.ps2_data != SC_EXT) && (bus.ps2_data != SC_BRK);
        end
      endcase
    end else if (w_timeout) begin
      w_state_next = ST_IDLE;
    end
  end

  assign w_key       = key_lookup(bus.ps2_data, w_ext);
  assign w_held_full = {r_held, 1'b0};
  assign w_hit       = w_decode && (w_key != KEY_NONE);
  // Repeat filter: a make for a key already down is typematic, not a new press.
  assign w_push      = w_hit && (w_is_break || !((FILTER_REPEAT != 0) && w_held_full[w_key]));
  assign w_pop       = !w_empty && bus.evt_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_last_byte <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (bus.ps2_data_en || r_state == ST_IDLE || w_timeout) r_timer <= '0;
      else                                                    r_timer <= r_timer + TW'(1);
      if (bus.ps2_data_en) r_last_byte <= bus.ps2_data;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  for (genvar gi = 1; gi < 8; gi++) begin : g_held
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_held[gi] <= 1'b0;
      end else if (w_hit && w_key == 3'(gi)) begin
        r_held[gi] <= !w_is_break;
      end
    end
  end

  ps2_key_decoder_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_din   ({w_is_break, w_key}),
    .i_pop   (bus.evt_ready),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.evt_valid   = !w_empty;
  assign bus.evt_release = w_empty ? 1'b0 : w_head.is_break;
  assign bus.evt_key     = w_empty ? 3'd0 : w_head.key;
  assign bus.held        = w_held_full;
  assign bus.last_byte   = r_last_byte;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: scenario tasks push expected events into a queue,
// a negedge monitor compares every popped event against it.
module tb_ps2_key_decoder;
  localparam int unsigned TMO = 16;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_errors;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_REPEAT  (1)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Handshake completes on the next posedge; compare the head now.
  always @(negedge clock) begin
    if (resetn && bus.evt_valid && bus.evt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL evt_unexpected got rel=%0d key=%0d required none",
                 bus.evt_release, bus.evt_key);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.evt_release, bus.evt_key} !== mon_exp) begin
          n_errors++;
          $display("FAIL evt_order got rel=%0d key=%0d required rel=%0d key=%0d",
                   bus.evt_release, bus.evt_key, mon_exp[3], mon_exp[2:0]);
        end else begin
          $display("EVT rel=%0d key=%0d ok", bus.evt_release, bus.evt_key);
        end
      end
    end
  end

  task automatic expect_evt(input logic rel, input logic [2:0] key);
    exp_q.push_back({rel, key});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    bus.ps2_data    = b;
    bus.ps2_data_en = 1'b1;
    @(posedge clock); #1;
    bus.ps2_data_en = 1'b0;
  endtask

  task automatic wait_drained(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !bus.evt_valid) begin
        ok = 1'b1;
        return;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    resetn          = 1'b0;
    bus.ps2_data_en = 1'b0;
    bus.evt_ready   = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.evt_valid, bus.evt_release, bus.evt_key, bus.held, bus.last_byte, bus.overflow} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got v=%0d r=%0d k=%0d held=%h lb=%h ovf=%0d required all 0",
               bus.evt_valid, bus.evt_release, bus.evt_key, bus.held, bus.last_byte, bus.overflow);
    end
  endtask

  task automatic test_make_repeat_break();
    bit ok;
    bus.evt_ready = 1'b1;
    expect_evt(1'b0, 3'd1);
    send_byte(8'h1D);
    n_checks++;
    if (bus.held !== 8'h02) begin
      n_errors++; $display("FAIL make_held got %h required 02", bus.held);
    end
    send_byte(8'h1D);
    expect_evt(1'b1, 3'd1);
    send_byte(8'hF0);
    send_byte(8'h1D);
    n_checks++;
    if (bus.held !== 8'h00) begin
      n_errors++; $display("FAIL break_held got %h required 00", bus.held);
    end
    wait_drained(ok);
    n_checks++;
    if (!ok) begin
      n_errors++; $display("FAIL basic_drain got %0d pending required 0", exp_q.size());
    end
    n_checks++;
    if (bus.last_byte !== 8'h1D) begin
      n_errors++; $display("FAIL last_byte got %h required 1d", bus.last_byte);
    end
  endtask

  task automatic test_extended();
    bit ok;
    bus.evt_ready = 1'b1;
    expect_evt(1'b0, 3'd4);
    send_byte(8'hE0);
    send_byte(8'h74);
    n_checks++;
    if (bus.held !== 8'h10) begin
      n_errors++; $display("FAIL ext_make_held got %h required 10", bus.held);
    end
    expect_evt(1'b1, 3'd4);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    n_checks++;
    if (bus.held !== 8'h00) begin
      n_errors++; $display("FAIL ext_break_held got %h required 00", bus.held);
    end
    send_byte(8'hE0);
    send_byte(8'h1D);
    wait_drained(ok);
    n_checks++;
    if (!ok || bus.held !== 8'h00) begin
      n_errors++; $display("FAIL ext_drain got pending=%0d held=%h required 0/00", exp_q.size(), bus.held);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    expect_evt(1'b0, 3'd1); send_byte(8'h1D);
    expect_evt(1'b0, 3'd2); send_byte(8'h1B);
    expect_evt(1'b0, 3'd3); send_byte(8'h1C);
    expect_evt(1'b0, 3'd4); send_byte(8'h23);
    send_byte(8'h29);
    n_checks++;
    if ({bus.evt_valid, bus.overflow} !== 2'b11) begin
      n_errors++; $display("FAIL ovf_flags got v=%0d ovf=%0d required 1/1", bus.evt_valid, bus.overflow);
    end
    n_checks++;
    if (bus.held !== 8'h3E) begin
      n_errors++; $display("FAIL ovf_held got %h required 3e", bus.held);
    end
    n_checks++;
    if (bus.evt_key !== 3'd1 || bus.evt_release !== 1'b0) begin
      n_errors++; $display("FAIL ovf_head got rel=%0d key=%0d required 0/1", bus.evt_release, bus.evt_key);
    end
    bus.evt_ready = 1'b1;
    wait_drained(ok);
    n_checks++;
    if (!ok || bus.overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_drain got pending=%0d ovf=%0d required 0/1", exp_q.size(), bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    expect_evt(1'b0, 3'd1); send_byte(8'h1D);
    expect_evt(1'b0, 3'd2); send_byte(8'h1B);
    expect_evt(1'b0, 3'd3); send_byte(8'h1C);
    expect_evt(1'b0, 3'd4); send_byte(8'h23);
    expect_evt(1'b0, 3'd5);
    @(posedge clock); #1;
    bus.ps2_data    = 8'h29;
    bus.ps2_data_en = 1'b1;
    bus.evt_ready   = 1'b1;
    @(posedge clock); #1;
    bus.ps2_data_en = 1'b0;
    bus.evt_ready   = 1'b0;
    n_checks++;
    if ({bus.evt_valid, bus.overflow} !== 2'b10) begin
      n_errors++; $display("FAIL full_pushpop_flags got v=%0d ovf=%0d required 1/0", bus.evt_valid, bus.overflow);
    end
    n_checks++;
    if (bus.evt_key !== 3'd2) begin
      n_errors++; $display("FAIL full_pushpop_head got %0d required 2", bus.evt_key);
    end
    bus.evt_ready = 1'b1;
    wait_drained(ok);
    n_checks++;
    if (!ok || bus.overflow !== 1'b0) begin
      n_errors++; $display("FAIL full_pushpop_drain got pending=%0d ovf=%0d required 0/0", exp_q.size(), bus.overflow);
    end
  endtask

  task automatic test_timeout_malformed();
    bit ok;
    do_reset();
    bus.evt_ready = 1'b1;
    send_byte(8'hE0);
    repeat (TMO + 4) @(posedge clock);
    #1;
    send_byte(8'h75);
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (bus.evt_valid !== 1'b0 || bus.held !== 8'h00) begin
      n_errors++; $display("FAIL timeout got v=%0d held=%h required 0/00", bus.evt_valid, bus.held);
    end
    expect_evt(1'b0, 3'd1);
    send_byte(8'h1D);
    wait_drained(ok);
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'h1D);
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (!ok || bus.evt_valid !== 1'b0 || bus.held !== 8'h02) begin
      n_errors++; $display("FAIL malformed got ok=%0d v=%0d held=%h required 1/0/02", ok, bus.evt_valid, bus.held);
    end
    expect_evt(1'b0, 3'd2);
    send_byte(8'h1B);
    wait_drained(ok);
    n_checks++;
    if (!ok || bus.held !== 8'h06) begin
      n_errors++; $display("FAIL idle_after_malformed got ok=%0d held=%h required 1/06", ok, bus.held);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    expect_evt(1'b0, 3'd1);
    send_byte(8'h1D);
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(posedge clock); #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({bus.evt_valid, bus.evt_release, bus.evt_key, bus.held, bus.last_byte, bus.overflow} !== '0) begin
      n_errors++;
      $display("FAIL async_reset got v=%0d k=%0d held=%h lb=%h required all 0",
               bus.evt_valid, bus.evt_key, bus.held, bus.last_byte);
    end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    send_byte(8'h74);
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (bus.evt_valid !== 1'b0 || bus.held !== 8'h00 || bus.last_byte !== 8'h74) begin
      n_errors++; $display("FAIL post_reset_74 got v=%0d held=%h lb=%h required 0/00/74",
                           bus.evt_valid, bus.held, bus.last_byte);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    resetn          = 1'b0;
    bus.ps2_data    = 8'h00;
    bus.ps2_data_en = 1'b0;
    bus.evt_ready   = 1'b0;
    test_reset();
    test_make_repeat_break();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_timeout_malformed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
